chi_hn_txn_tracker: RTL and testbench

Parametrised CHI home-node request tracker that supersedes the fixed single-RN request/response path.
- Arbitrates NUM_RN request-node channels round-robin.
- Allocates a transaction ID per accepted request from a TRK_DEPTH-entry table and blocks same-line address hazards.
- Forwards each request to the slave node and routes SN responses back to the originating RN by transaction ID.
- Sits between the RN-side request/response channels and the SN port inside the CHI top.

---
 rtl/chi_hn_txn_tracker_if.sv | 53 +++++
 rtl/chi_hn_txn_tracker.sv | 168 ++++++++++++++++
 tb/tb_chi_hn_txn_tracker.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chi_hn_txn_tracker_if.sv
// RN-side request/response and SN-side channels of the CHI home-node tracker.
// master is the surrounding fabric, slave is the tracker itself.
interface chi_hn_txn_tracker_if #(
    parameter int NUM_RN = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ID_W   = 3
);
    logic [NUM_RN-1:0]        rn_req_valid;
    logic [NUM_RN-1:0]        rn_req_ready;
    logic [NUM_RN*ADDR_W-1:0] rn_req_addr;
    logic [NUM_RN*3-1:0]      rn_req_type;
    logic [NUM_RN*DATA_W-1:0] rn_req_data;

    logic                     sn_req_valid;
    logic                     sn_req_ready;
    logic [ADDR_W-1:0]        sn_req_addr;
    logic [2:0]               sn_req_type;
    logic [DATA_W-1:0]        sn_req_data;
    logic [ID_W-1:0]          sn_req_txnid;

    logic                     sn_resp_valid;
    logic                     sn_resp_ready;
    logic [ID_W-1:0]          sn_resp_txnid;
    logic [DATA_W-1:0]        sn_resp_data;
    logic [2:0]               sn_resp_status;

    logic [NUM_RN-1:0]        rn_resp_valid;
    logic [NUM_RN-1:0]        rn_resp_ready;
    logic [DATA_W-1:0]        rn_resp_data;
    logic [2:0]               rn_resp_status;

    logic [ID_W:0]            trk_count;
    logic                     err_bad_txnid;

    modport master (
        output rn_req_valid, rn_req_addr, rn_req_type, rn_req_data,
        output sn_req_ready, sn_resp_valid, sn_resp_txnid, sn_resp_data, sn_resp_status,
        output rn_resp_ready,
        input  rn_req_ready, sn_req_valid, sn_req_addr, sn_req_type, sn_req_data, sn_req_txnid,
        input  sn_resp_ready, rn_resp_valid, rn_resp_data, rn_resp_status,
        input  trk_count, err_bad_txnid
    );

    modport slave (
        input  rn_req_valid, rn_req_addr, rn_req_type, rn_req_data,
        input  sn_req_ready, sn_resp_valid, sn_resp_txnid, sn_resp_data, sn_resp_status,
        input  rn_resp_ready,
        output rn_req_ready, sn_req_valid, sn_req_addr, sn_req_type, sn_req_data, sn_req_txnid,
        output sn_resp_ready, rn_resp_valid, rn_resp_data, rn_resp_status,
        output trk_count, err_bad_txnid
    );
endinterface

// File: rtl/chi_hn_txn_tracker.sv
// CHI home-node request tracker: round-robin RN arbitration, txnid allocation with
// same-line hazard blocking, SN forwarding and response routing by txnid.
//
// state         | meaning
// ST_FREE       | entry unused, may be allocated
// ST_ISSUED     | request forwarded to SN, waiting for its response
// ST_RESPONDING | response held on rn_resp, waiting for the RN handshake
module chi_hn_txn_tracker #(
    parameter int NUM_RN    = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int TRK_DEPTH = 8,
    parameter int LINE_OFF  = 6,
    parameter int ID_W      = 3
) (
    input  logic clk,
    input  logic reset,
    chi_hn_txn_tracker_if.slave bus
);
    localparam int RR_W  = (NUM_RN > 1) ? $clog2(NUM_RN) : 1;
    localparam int TAG_W = ADDR_W - LINE_OFF;

    typedef enum logic [1:0] {
        ST_FREE       = 2'd0,
        ST_ISSUED     = 2'd1,
        ST_RESPONDING = 2'd2
    } ent_state_t;

    ent_state_t        ent_state  [TRK_DEPTH];
    logic [RR_W-1:0]   ent_src    [TRK_DEPTH];
    logic [TAG_W-1:0]  ent_tag    [TRK_DEPTH];
    logic [DATA_W-1:0] ent_data   [TRK_DEPTH];
    logic [2:0]        ent_status [TRK_DEPTH];

    logic [RR_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   resp_ent;
    logic [NUM_RN-1:0] resp_valid_q;
    logic              sn_valid_q;
    logic [ADDR_W-1:0] sn_addr_q;
    logic [2:0]        sn_type_q;
    logic [DATA_W-1:0] sn_data_q;
    logic [ID_W-1:0]   sn_txnid_q;
    logic              err_q;
    logic [ID_W:0]     count_q;

    logic [NUM_RN-1:0] eligible;
    logic              grant_found;
    logic [RR_W-1:0]   grant_idx;
    logic [ADDR_W-1:0] grant_addr;
    logic [2:0]        grant_type;
    logic [DATA_W-1:0] grant_data;
    logic              free_found;
    logic [ID_W-1:0]   free_idx;
    int                scan;
    logic              accept;
    logic              resp_drain;
    logic              resp_ready;
    logic              resp_accept;
    logic              resp_hit;

    always_comb begin
        eligible    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_addr  = '0;
        grant_type  = '0;
        grant_data  = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        scan        = 0;
        for (int i = 0; i < NUM_RN; i++) begin
            eligible[i] = bus.rn_req_valid[i];
            for (int j = 0; j < TRK_DEPTH; j++) begin
                if (ent_state[j] != ST_FREE &&
                    ent_tag[j] == bus.rn_req_addr[i*ADDR_W+LINE_OFF +: TAG_W])
                    eligible[i] = 1'b0;
            end
        end
        for (int k = 0; k < NUM_RN; k++) begin
            scan = (int'(rr_ptr) + k) % NUM_RN;
            if (!grant_found && eligible[scan]) begin
                grant_found = 1'b1;
                grant_idx   = RR_W'(scan);
                grant_addr  = bus.rn_req_addr[scan*ADDR_W +: ADDR_W];
                grant_type  = bus.rn_req_type[scan*3 +: 3];
                grant_data  = bus.rn_req_data[scan*DATA_W +: DATA_W];
            end
        end
        // Descending scan leaves the lowest FREE index selected.
        for (int j = TRK_DEPTH - 1; j >= 0; j--) begin
            if (ent_state[j] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = ID_W'(j);
            end
        end
    end

    assign accept      = !reset && grant_found && free_found && (!sn_valid_q || bus.sn_req_ready);
    assign resp_drain  = |(resp_valid_q & bus.rn_resp_ready);
    assign resp_ready  = !reset && (resp_valid_q == '0 || resp_drain);
    assign resp_accept = bus.sn_resp_valid && resp_ready;
    assign resp_hit    = resp_accept && ent_state[bus.sn_resp_txnid] == ST_ISSUED;

    assign bus.rn_req_ready   = accept ? (NUM_RN'(1) << grant_idx) : '0;
    assign bus.sn_resp_ready  = resp_ready;
    assign bus.sn_req_valid   = sn_valid_q;
    assign bus.sn_req_addr    = sn_addr_q;
    assign bus.sn_req_type    = sn_type_q;
    assign bus.sn_req_data    = sn_data_q;
    assign bus.sn_req_txnid   = sn_txnid_q;
    assign bus.rn_resp_valid  = resp_valid_q;
    assign bus.rn_resp_data   = ent_data[resp_ent];
    assign bus.rn_resp_status = ent_status[resp_ent];
    assign bus.trk_count      = count_q;
    assign bus.err_bad_txnid  = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < TRK_DEPTH; j++) begin
                ent_state[j]  <= ST_FREE;
                ent_src[j]    <= '0;
                ent_tag[j]    <= '0;
                ent_data[j]   <= '0;
                ent_status[j] <= '0;
            end
            rr_ptr       <= '0;
            resp_ent     <= '0;
            resp_valid_q <= '0;
            sn_valid_q   <= 1'b0;
            sn_addr_q    <= '0;
            sn_type_q    <= '0;
            sn_data_q    <= '0;
            sn_txnid_q   <= '0;
            err_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            if (accept) begin
                ent_state[free_idx] <= ST_ISSUED;
                ent_src[free_idx]   <= grant_idx;
                ent_tag[free_idx]   <= grant_addr[ADDR_W-1:LINE_OFF];
                rr_ptr      <= (grant_idx == RR_W'(NUM_RN - 1)) ? '0 : grant_idx + 1'b1;
                sn_valid_q  <= 1'b1;
                sn_addr_q   <= grant_addr;
                sn_type_q   <= grant_type;
                sn_data_q   <= grant_data;
                sn_txnid_q  <= free_idx;
            end else if (bus.sn_req_ready) begin
                sn_valid_q <= 1'b0;
            end

            // Drain and reload can coincide; the reload wins the valid register.
            if (resp_drain) begin
                ent_state[resp_ent] <= ST_FREE;
                resp_valid_q        <= '0;
            end
            if (resp_hit) begin
                ent_state[bus.sn_resp_txnid]  <= ST_RESPONDING;
                ent_data[bus.sn_resp_txnid]   <= bus.sn_resp_data;
                ent_status[bus.sn_resp_txnid] <= bus.sn_resp_status;
                resp_ent     <= bus.sn_resp_txnid;
                resp_valid_q <= NUM_RN'(1) << ent_src[bus.sn_resp_txnid];
            end

            err_q   <= resp_accept && !resp_hit;
            count_q <= count_q + (ID_W+1)'(accept) - (ID_W+1)'(resp_drain);
        end
    end
endmodule

// File: tb/tb_chi_hn_txn_tracker.sv
// Directed scenarios plus a randomized run against a transaction-list reference model.
module tb_chi_hn_txn_tracker;
    localparam int NUM_RN = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 8;
    localparam int ID_W   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    chi_hn_txn_tracker_if #(.NUM_RN(NUM_RN), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    chi_hn_txn_tracker #(.NUM_RN(NUM_RN), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                         .TRK_DEPTH(DEPTH), .LINE_OFF(6), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Outstanding transactions as the specification describes them.
    typedef struct {
        int          id;
        int          src;
        logic [31:0] addr;
        bit          answered;
    } rec_t;
    rec_t outq[$];

    function automatic int find_id(int id);
        foreach (outq[k]) if (outq[k].id == id) return k;
        return -1;
    endfunction

    function automatic bit line_busy(logic [31:0] a);
        foreach (outq[k]) if (outq[k].addr[31:6] == a[31:6]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lowest_free_id();
        for (int id = 0; id < DEPTH; id++) if (find_id(id) < 0) return id;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rn_req_valid   = '0;
        bus.rn_req_addr    = '0;
        bus.rn_req_type    = '0;
        bus.rn_req_data    = '0;
        bus.sn_req_ready   = 1'b0;
        bus.sn_resp_valid  = 1'b0;
        bus.sn_resp_txnid  = '0;
        bus.sn_resp_data   = '0;
        bus.sn_resp_status = '0;
        bus.rn_resp_ready  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_addrs(int base, int k);
        for (int i = 0; i < NUM_RN; i++)
            bus.rn_req_addr[i*ADDR_W +: ADDR_W] = 32'(base + (k*NUM_RN + i) * 64);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        bus.rn_req_valid  = '1;
        bus.sn_resp_valid = 1'b1;
        tick();
        tick();
        total++; if (bus.rn_req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0000", bus.rn_req_ready); end
        total++; if (bus.sn_resp_ready !== 1'b0) begin bad++; $display("FAIL rst_sn_resp_ready got=%b exp=0", bus.sn_resp_ready); end
        total++; if (bus.sn_req_valid !== 1'b0) begin bad++; $display("FAIL rst_sn_req_valid got=%b exp=0", bus.sn_req_valid); end
        total++; if (bus.rn_resp_valid !== 4'b0) begin bad++; $display("FAIL rst_rn_resp_valid got=%b exp=0000", bus.rn_resp_valid); end
        total++; if (bus.err_bad_txnid !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err_bad_txnid); end
        clear_inputs();
        reset = 1'b0;
        #1;
        total++; if (bus.trk_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.trk_count); end
        total++; if (bus.sn_resp_ready !== 1'b1) begin bad++; $display("FAIL rst_sn_resp_ready_after got=%b exp=1", bus.sn_resp_ready); end
        total++; if ({bus.sn_req_addr, bus.sn_req_txnid, bus.sn_req_type} !== '0) begin bad++; $display("FAIL rst_sn_fields got=%h/%h/%h exp=0", bus.sn_req_addr, bus.sn_req_txnid, bus.sn_req_type); end
        total++; if ({bus.rn_resp_data, bus.rn_resp_status} !== '0) begin bad++; $display("FAIL rst_resp_fields got=%h/%h exp=0", bus.rn_resp_data, bus.rn_resp_status); end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        bus.rn_req_valid = 4'b0010;
        bus.rn_req_addr[1*ADDR_W +: ADDR_W] = 32'h1000;
        bus.rn_req_type[1*3 +: 3] = 3'd2;
        bus.rn_req_data[1*DATA_W +: DATA_W] = 128'h1234;
        #1;
        total++; if (bus.rn_req_ready !== 4'b0010) begin bad++; $display("FAIL single_req_ready got=%b exp=0010", bus.rn_req_ready); end
        tick();
        bus.rn_req_valid = '0;
        total++; if (bus.sn_req_valid !== 1'b1 || bus.sn_req_txnid !== 3'd0 || bus.sn_req_addr !== 32'h1000 || bus.sn_req_type !== 3'd2 || bus.sn_req_data !== 128'h1234)
            begin bad++; $display("FAIL single_sn_req got=v%b id%0d a%h t%0d d%h exp=v1 id0 a1000 t2 d1234", bus.sn_req_valid, bus.sn_req_txnid, bus.sn_req_addr, bus.sn_req_type, bus.sn_req_data); end
        total++; if (bus.trk_count !== 4'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", bus.trk_count); end
        bus.sn_req_ready = 1'b1;
        tick();
        bus.sn_req_ready = 1'b0;
        total++; if (bus.sn_req_valid !== 1'b0) begin bad++; $display("FAIL single_sn_drain got=%b exp=0", bus.sn_req_valid); end
        bus.sn_resp_valid = 1'b1;
        bus.sn_resp_txnid = 3'd0;
        bus.sn_resp_data  = 128'hAB;
        #1;
        total++; if (bus.sn_resp_ready !== 1'b1) begin bad++; $display("FAIL single_sn_resp_ready got=%b exp=1", bus.sn_resp_ready); end
        tick();
        bus.sn_resp_valid = 1'b0;
        total++; if (bus.rn_resp_valid !== 4'b0010 || bus.rn_resp_data !== 128'hAB || bus.rn_resp_status !== 3'd0)
            begin bad++; $display("FAIL single_rn_resp got=%b %h %0d exp=0010 ab 0", bus.rn_resp_valid, bus.rn_resp_data, bus.rn_resp_status); end
        bus.rn_resp_ready = 4'b0010;
        tick();
        bus.rn_resp_ready = '0;
        total++; if (bus.rn_resp_valid !== 4'b0 || bus.trk_count !== 4'd0) begin bad++; $display("FAIL single_done got=%b cnt%0d exp=0000 cnt0", bus.rn_resp_valid, bus.trk_count); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.sn_req_ready = 1'b1;
        bus.rn_req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            set_addrs(32'h10000, c);
            #1;
            total++; if (bus.rn_req_ready !== 4'(1 << (c % 4))) begin bad++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.rn_req_ready, 4'(1 << (c % 4))); end
            tick();
            total++; if (bus.sn_req_txnid !== 3'(c) || bus.sn_req_addr !== 32'(32'h10000 + (c*4 + c%4)*64))
                begin bad++; $display("FAIL rr_txn c=%0d got=id%0d a%h exp=id%0d", c, bus.sn_req_txnid, bus.sn_req_addr, c); end
        end
        clear_inputs();
    endtask

    task automatic test_hazard();
        do_reset();
        bus.sn_req_ready = 1'b1;
        bus.rn_req_valid = 4'b0001;
        bus.rn_req_addr[0 +: ADDR_W] = 32'h2000;
        #1;
        total++; if (bus.rn_req_ready !== 4'b0001) begin bad++; $display("FAIL hz_rn0 got=%b exp=0001", bus.rn_req_ready); end
        tick();
        bus.rn_req_valid = 4'b1100;
        bus.rn_req_addr[2*ADDR_W +: ADDR_W] = 32'h2030;
        bus.rn_req_addr[3*ADDR_W +: ADDR_W] = 32'h3000;
        #1;
        total++; if (bus.rn_req_ready !== 4'b1000) begin bad++; $display("FAIL hz_rn3 got=%b exp=1000", bus.rn_req_ready); end
        tick();
        bus.rn_req_valid = 4'b0100;
        bus.sn_resp_valid = 1'b1;
        bus.sn_resp_txnid = 3'd0;
        bus.sn_resp_data  = 128'h55;
        #1;
        total++; if (bus.rn_req_ready !== 4'b0) begin bad++; $display("FAIL hz_block1 got=%b exp=0000", bus.rn_req_ready); end
        tick();
        bus.sn_resp_valid = 1'b0;
        total++; if (bus.rn_resp_valid !== 4'b0001 || bus.rn_resp_data !== 128'h55) begin bad++; $display("FAIL hz_resp got=%b %h exp=0001 55", bus.rn_resp_valid, bus.rn_resp_data); end
        bus.rn_resp_ready = 4'b0001;
        #1;
        total++; if (bus.rn_req_ready !== 4'b0) begin bad++; $display("FAIL hz_block2 got=%b exp=0000", bus.rn_req_ready); end
        tick();
        bus.rn_resp_ready = '0;
        #1;
        total++; if (bus.rn_req_ready !== 4'b0100) begin bad++; $display("FAIL hz_release got=%b exp=0100", bus.rn_req_ready); end
        tick();
        bus.rn_req_valid = '0;
        total++; if (bus.sn_req_txnid !== 3'd0 || bus.sn_req_addr !== 32'h2030) begin bad++; $display("FAIL hz_reuse got=id%0d a%h exp=id0 a2030", bus.sn_req_txnid, bus.sn_req_addr); end
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        bus.sn_req_ready = 1'b1;
        bus.rn_req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            set_addrs(32'h20000, k);
            tick();
        end
        total++; if (bus.trk_count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", bus.trk_count); end
        set_addrs(32'h20000, 8);
        bus.sn_resp_valid = 1'b1;
        bus.sn_resp_txnid = 3'd5;
        bus.sn_resp_data  = 128'h5A5;
        #1;
        total++; if (bus.rn_req_ready !== 4'b0) begin bad++; $display("FAIL full_block got=%b exp=0000", bus.rn_req_ready); end
        tick();
        bus.sn_resp_valid = 1'b0;
        total++; if (bus.rn_resp_valid !== 4'b0010) begin bad++; $display("FAIL full_resp got=%b exp=0010", bus.rn_resp_valid); end
        bus.rn_resp_ready = 4'b0010;
        #1;
        total++; if (bus.rn_req_ready !== 4'b0) begin bad++; $display("FAIL full_same_cycle got=%b exp=0000", bus.rn_req_ready); end
        tick();
        bus.rn_resp_ready = '0;
        total++; if (bus.trk_count !== 4'd7) begin bad++; $display("FAIL full_count7 got=%0d exp=7", bus.trk_count); end
        #1;
        total++; if (bus.rn_req_ready !== 4'b0001) begin bad++; $display("FAIL full_one_accept got=%b exp=0001", bus.rn_req_ready); end
        tick();
        total++; if (bus.sn_req_txnid !== 3'd5 || bus.sn_req_addr !== 32'(32'h20000 + 32*64) || bus.trk_count !== 4'd8)
            begin bad++; $display("FAIL full_reuse got=id%0d a%h cnt%0d exp=id5 cnt8", bus.sn_req_txnid, bus.sn_req_addr, bus.trk_count); end
        set_addrs(32'h20000, 9);
        #1;
        total++; if (bus.rn_req_ready !== 4'b0) begin bad++; $display("FAIL full_again got=%b exp=0000", bus.rn_req_ready); end
        clear_inputs();
    endtask

    task automatic test_bad_txnid();
        do_reset();
        bus.sn_resp_valid = 1'b1;
        bus.sn_resp_txnid = 3'd5;
        tick();
        bus.sn_resp_valid = 1'b0;
        total++; if (bus.err_bad_txnid !== 1'b1 || bus.rn_resp_valid !== 4'b0) begin bad++; $display("FAIL bad_pulse got=err%b v%b exp=err1 v0000", bus.err_bad_txnid, bus.rn_resp_valid); end
        tick();
        total++; if (bus.err_bad_txnid !== 1'b0) begin bad++; $display("FAIL bad_one_cycle got=%b exp=0", bus.err_bad_txnid); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.sn_req_ready = 1'b1;
        bus.rn_req_valid = '1;
        for (int k = 0; k < 3; k++) begin
            set_addrs(32'h30000, k);
            tick();
        end
        bus.rn_req_valid = '0;
        bus.sn_req_ready = 1'b0;
        total++; if (bus.trk_count !== 4'd3 || bus.sn_req_valid !== 1'b1) begin bad++; $display("FAIL mid_before got=cnt%0d v%b exp=cnt3 v1", bus.trk_count, bus.sn_req_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.sn_req_valid !== 1'b0 || bus.trk_count !== 4'd0 || bus.rn_resp_valid !== 4'b0 || bus.sn_req_addr !== 32'd0)
            begin bad++; $display("FAIL mid_reset got=v%b cnt%0d rv%b a%h exp=0", bus.sn_req_valid, bus.trk_count, bus.rn_resp_valid, bus.sn_req_addr); end
        bus.sn_resp_valid = 1'b1;
        bus.sn_resp_txnid = 3'd1;
        tick();
        bus.sn_resp_valid = 1'b0;
        total++; if (bus.err_bad_txnid !== 1'b1 || bus.rn_resp_valid !== 4'b0) begin bad++; $display("FAIL mid_stale got=err%b v%b exp=err1 v0000", bus.err_bad_txnid, bus.rn_resp_valid); end
    endtask

    task automatic test_random();
        bit          e_sn_v = 1'b0;
        logic [31:0] e_sn_addr = '0;
        logic [2:0]  e_sn_type = '0;
        logic [127:0] e_sn_data = '0;
        int          e_sn_id = 0;
        bit          e_rs_v = 1'b0;
        int          e_rs_src = 0;
        int          e_rs_id = 0;
        logic [127:0] e_rs_data = '0;
        logic [2:0]  e_rs_status = '0;
        bit          e_err = 1'b0;
        int          rr = 0;
        int          pend[$];
        do_reset();
        outq.delete();
        for (int c = 0; c < 1500; c++) begin
            int g, fid, idx, ri;
            bit acc, srr, drain, racc, hit;
            logic [3:0] exp_rdy, exp_rv;
            for (int i = 0; i < NUM_RN; i++) begin
                bus.rn_req_valid[i] = ($urandom_range(0, 2) != 0);
                bus.rn_req_addr[i*ADDR_W +: ADDR_W] = 32'h4000_0000 + 32'($urandom_range(0, 11) * 64 + $urandom_range(0, 63));
                bus.rn_req_type[i*3 +: 3] = 3'($urandom);
                bus.rn_req_data[i*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
            end
            bus.sn_req_ready  = ($urandom_range(0, 3) != 0);
            bus.rn_resp_ready = 4'($urandom);
            bus.sn_resp_valid = ($urandom_range(0, 4) < 2);
            pend.delete();
            foreach (outq[k]) if (!outq[k].answered) pend.push_back(outq[k].id);
            if (pend.size() > 0 && $urandom_range(0, 7) != 0)
                bus.sn_resp_txnid = 3'(pend[$urandom_range(0, pend.size() - 1)]);
            else
                bus.sn_resp_txnid = 3'($urandom_range(0, 7));
            bus.sn_resp_data   = {$urandom, $urandom, $urandom, $urandom};
            bus.sn_resp_status = 3'($urandom);
            #1;
            exp_rv = e_rs_v ? 4'(1 << e_rs_src) : 4'b0;
            total++; if (bus.sn_req_valid !== e_sn_v || (e_sn_v && (bus.sn_req_addr !== e_sn_addr || bus.sn_req_txnid !== 3'(e_sn_id) || bus.sn_req_type !== e_sn_type || bus.sn_req_data !== e_sn_data)))
                begin bad++; $display("FAIL rnd_sn_req c=%0d got=v%b a%h id%0d exp=v%b a%h id%0d", c, bus.sn_req_valid, bus.sn_req_addr, bus.sn_req_txnid, e_sn_v, e_sn_addr, e_sn_id); end
            total++; if (bus.rn_resp_valid !== exp_rv || (e_rs_v && (bus.rn_resp_data !== e_rs_data || bus.rn_resp_status !== e_rs_status)))
                begin bad++; $display("FAIL rnd_rn_resp c=%0d got=%b %h %0d exp=%b %h %0d", c, bus.rn_resp_valid, bus.rn_resp_data, bus.rn_resp_status, exp_rv, e_rs_data, e_rs_status); end
            total++; if (bus.trk_count !== 4'(outq.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.trk_count, outq.size()); end
            total++; if (bus.err_bad_txnid !== e_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, bus.err_bad_txnid, e_err); end

            g = -1;
            for (int k = 0; k < NUM_RN; k++) begin
                ri = (rr + k) % NUM_RN;
                if (g < 0 && bus.rn_req_valid[ri] && !line_busy(bus.rn_req_addr[ri*ADDR_W +: ADDR_W])) g = ri;
            end
            fid = lowest_free_id();
            acc = (g >= 0) && (fid >= 0) && (!e_sn_v || bus.sn_req_ready);
            exp_rdy = acc ? 4'(1 << g) : 4'b0;
            srr = !e_rs_v || bus.rn_resp_ready[e_rs_src];
            total++; if (bus.rn_req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_req_ready c=%0d got=%b exp=%b", c, bus.rn_req_ready, exp_rdy); end
            total++; if (bus.sn_resp_ready !== srr) begin bad++; $display("FAIL rnd_sn_resp_ready c=%0d got=%b exp=%b", c, bus.sn_resp_ready, srr); end

            drain = e_rs_v && bus.rn_resp_ready[e_rs_src];
            racc  = bus.sn_resp_valid && srr;
            idx   = find_id(int'(bus.sn_resp_txnid));
            hit   = racc && idx >= 0 && !outq[idx].answered;
            if (hit) outq[idx].answered = 1'b1;
            if (drain) begin
                outq.delete(find_id(e_rs_id));
                e_rs_v = 1'b0;
            end
            if (hit) begin
                e_rs_v      = 1'b1;
                e_rs_id     = int'(bus.sn_resp_txnid);
                e_rs_src    = outq[find_id(e_rs_id)].src;
                e_rs_data   = bus.sn_resp_data;
                e_rs_status = bus.sn_resp_status;
            end
            e_err = racc && !hit;
            if (acc) begin
                outq.push_back('{id: fid, src: g, addr: bus.rn_req_addr[g*ADDR_W +: ADDR_W], answered: 1'b0});
                rr        = (g + 1) % NUM_RN;
                e_sn_v    = 1'b1;
                e_sn_id   = fid;
                e_sn_addr = bus.rn_req_addr[g*ADDR_W +: ADDR_W];
                e_sn_type = bus.rn_req_type[g*3 +: 3];
                e_sn_data = bus.rn_req_data[g*DATA_W +: DATA_W];
            end else if (bus.sn_req_ready) begin
                e_sn_v = 1'b0;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_hazard();
        test_full();
        test_bad_txnid();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
